// File: rtl/instr_mem_sync.sv
// ---------------------------------------------------------------------------
// instr_mem_sync
//   Synchronous-read instruction memory for the pipelined MIPS core. The
//   registered read port is also the IF/ID instruction register. A load port
//   fed by the UART bootloader writes the program through an auto-incrementing
//   pointer while the block sits in LOAD mode.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   fetch_en       fetch request this cycle
//   stall          hold current fetch outputs (IF/ID stall)
//   flush          squash fetch outputs (branch/jump/exception)
//   addr           byte address of the fetch (PC)
//   instruction    registered instruction word
//   inst_valid     instruction holds a real fetched word
//   addr_fault     current output came from a misaligned/out-of-range address
//   load_start     enter LOAD mode and restart the load session
//   load_we        write load_data at the pointer, then advance the pointer
//   load_data      program word
//   load_end       leave LOAD mode
//   loading        high while in LOAD
//   load_count     words accepted this session (saturates at DEPTH)
//   load_overflow  sticky: a write was dropped because the memory was full
// ---------------------------------------------------------------------------
module instr_mem_sync #(
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH_LOG2 = 7,
    parameter logic [DATA_W-1:0]  NOP_WORD   = '0,
    parameter bit                 IGNORE_MSB = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [31:0]           addr,
    output logic [DATA_W-1:0]     instruction,
    output logic                  inst_valid,
    output logic                  addr_fault,
    input  logic                  load_start,
    input  logic                  load_we,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  load_end,
    output logic                  loading,
    output logic [DEPTH_LOG2:0]   load_count,
    output logic                  load_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Address bits that must be zero for an in-range fetch: everything above
    // the word index, optionally leaving out the supervisor bit.
    localparam logic [31:0] RANGE_MASK =
        (32'hFFFF_FFFF << (DEPTH_LOG2 + 2)) & (32'hFFFF_FFFF >> IGNORE_MSB);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic mem_full;
    logic wr_en;
    logic bad_addr;
    logic force_nop;

    // ---- control: mode FSM and write qualification ----
    always_comb begin
        state_next = state;
        case (state)
            RUN:  if (load_start) state_next = LOAD;
            LOAD: if (load_start) state_next = LOAD;
                  else if (load_end) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // The count MSB is set only when the count has reached DEPTH.
    assign mem_full  = load_count[DEPTH_LOG2];
    // A restart in the same cycle discards the write.
    assign wr_en     = (state == LOAD) && load_we && !load_start && !mem_full;
    assign bad_addr  = (|addr[1:0]) || (|(addr & RANGE_MASK));
    // Entering LOAD already blanks the outputs so they stay NOP for the whole
    // time loading is high.
    assign force_nop = (state == LOAD) || load_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            loading       <= 1'b0;
            load_count    <= '0;
            load_overflow <= 1'b0;
        end else begin
            state   <= state_next;
            loading <= (state_next == LOAD);
            if (load_start) begin
                load_count    <= '0;
                load_overflow <= 1'b0;
            end else if ((state == LOAD) && load_we) begin
                if (mem_full) load_overflow <= 1'b1;
                else          load_count    <= load_count + 1'b1;
            end
        end
    end

    // ---- storage: not reset, contents survive reset ----
    always_ff @(posedge clk) begin
        if (wr_en) mem[load_count[DEPTH_LOG2-1:0]] <= load_data;
    end

    // ---- fetch register (IF/ID) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (force_nop || flush) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (stall) begin
            instruction <= instruction;
            inst_valid  <= inst_valid;
            addr_fault  <= addr_fault;
        end else if (fetch_en) begin
            if (bad_addr) begin
                instruction <= NOP_WORD;
                inst_valid  <= 1'b0;
                addr_fault  <= 1'b1;
            end else begin
                instruction <= mem[addr[DEPTH_LOG2+1:2]];
                inst_valid  <= 1'b1;
                addr_fault  <= 1'b0;
            end
        end else begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_sync
//   Three instances share one stimulus: default parameters, a 4-word memory
//   (DEPTH_LOG2=2) and one with the supervisor bit included in the range
//   check (IGNORE_MSB=0). Every cycle all outputs of all three are compared
//   with a behavioural model derived from the mode/fetch/load rules.
// ---------------------------------------------------------------------------
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en, stall, flush, load_start, load_we, load_end;
    logic [31:0] addr, load_data;

    logic [31:0] i0, i1, i2;
    logic        v0, v1, v2, f0, f1, f2, ld0, ld1, ld2, ov0, ov1, ov2;
    logic [7:0]  lc0, lc2;
    logic [2:0]  lc1;

    always #5 clk = ~clk;

    instr_mem_sync #(.DATA_W(32), .DEPTH_LOG2(7), .NOP_WORD(32'h0), .IGNORE_MSB(1'b1)) u_main (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall), .flush(flush),
        .addr(addr), .instruction(i0), .inst_valid(v0), .addr_fault(f0),
        .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_end(load_end),
        .loading(ld0), .load_count(lc0), .load_overflow(ov0));

    instr_mem_sync #(.DATA_W(32), .DEPTH_LOG2(2), .NOP_WORD(32'h0), .IGNORE_MSB(1'b1)) u_small (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall), .flush(flush),
        .addr(addr), .instruction(i1), .inst_valid(v1), .addr_fault(f1),
        .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_end(load_end),
        .loading(ld1), .load_count(lc1), .load_overflow(ov1));

    instr_mem_sync #(.DATA_W(32), .DEPTH_LOG2(7), .NOP_WORD(32'h0), .IGNORE_MSB(1'b0)) u_nomsb (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall), .flush(flush),
        .addr(addr), .instruction(i2), .inst_valid(v2), .addr_fault(f2),
        .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_end(load_end),
        .loading(ld2), .load_count(lc2), .load_overflow(ov2));

    // ---- behavioural model ----
    int          total = 0;
    int          bad   = 0;
    int          m_l2  [3] = '{7, 2, 7};
    bit          m_ign [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] m_mem [3][128];
    bit          m_load[3];
    int          m_cnt [3];
    bit          m_ovf [3];
    logic [31:0] m_ins [3];
    bit          m_vld [3];
    bit          m_flt [3];

    function automatic bit is_bad(int k, logic [31:0] a);
        longint eff;
        eff = m_ign[k] ? longint'(a & 32'h7FFF_FFFF) : longint'(a);
        return ((a % 4) != 0) || (eff >= (longint'(4) << m_l2[k]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_load[k] = 1'b0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            m_ins[k] = NOP; m_vld[k] = 1'b0; m_flt[k] = 1'b0;
        end
    endtask

    // Applies one rising edge to the model using the current input values.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (m_load[k] || load_start || flush) begin
                m_ins[k] = NOP; m_vld[k] = 1'b0; m_flt[k] = 1'b0;
            end else if (stall) begin
                // hold
            end else if (fetch_en) begin
                if (is_bad(k, addr)) begin
                    m_ins[k] = NOP; m_vld[k] = 1'b0; m_flt[k] = 1'b1;
                end else begin
                    m_ins[k] = m_mem[k][addr >> 2]; m_vld[k] = 1'b1; m_flt[k] = 1'b0;
                end
            end else begin
                m_vld[k] = 1'b0;
            end
            if (load_start) begin
                m_load[k] = 1'b1; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            end else if (m_load[k]) begin
                if (load_we) begin
                    if (m_cnt[k] < (1 << m_l2[k])) begin
                        m_mem[k][m_cnt[k]] = load_data;
                        m_cnt[k]++;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
                if (load_end) m_load[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic [31:0] ins, input logic v, input logic f,
                            input logic ld, input logic [7:0] lc, input logic ov);
        chk("instruction",   k, {32'b0, ins}, {32'b0, m_ins[k]});
        chk("inst_valid",    k, {63'b0, v},   {63'b0, m_vld[k]});
        chk("addr_fault",    k, {63'b0, f},   {63'b0, m_flt[k]});
        chk("loading",       k, {63'b0, ld},  {63'b0, m_load[k]});
        chk("load_count",    k, {56'b0, lc},  64'(m_cnt[k]));
        chk("load_overflow", k, {63'b0, ov},  {63'b0, m_ovf[k]});
    endtask

    task automatic check_all();
        chk_inst(0, i0, v0, f0, ld0, lc0, ov0);
        chk_inst(1, i1, v1, f1, ld1, {5'b0, lc1}, ov1);
        chk_inst(2, i2, v2, f2, ld2, lc2, ov2);
    endtask

    // One clock cycle with the given inputs, checked just after the edge.
    task automatic cyc(input bit fe, input bit st, input bit fl, input logic [31:0] a,
                       input bit ls, input bit we, input logic [31:0] d, input bit le);
        fetch_en = fe; stall = st; flush = fl; addr = a;
        load_start = ls; load_we = we; load_data = d; load_end = le;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(1, 0, 0, a, 0, 0, 32'h0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        fetch_en = 0; stall = 0; flush = 0; addr = 0;
        load_start = 0; load_we = 0; load_data = 0; load_end = 0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 128; j++) m_mem[k][j] = 32'h0;

        // power-up reset
        #1 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk) reset = 1'b0;

        // fill the whole memory so every later fetch has a known word
        cyc(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
        for (int j = 0; j < 128; j++) cyc(0, 0, 0, 32'h0, 0, 1, $urandom, j == 127);
        idle();

        // load three words then fetch them back-to-back
        cyc(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h2008_0014, 0);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h0100_0008, 0);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h3c10_4000, 0);
        cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        idle();

        // five writes: the 4-word instance saturates and flags overflow
        cyc(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 0, 0, 32'h0, 0, 1, $urandom, 0);
        cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        for (int j = 0; j < 5; j++) fetch(32'(j * 4));

        // faults: misaligned, out of range, supervisor bit
        fetch(32'h0000_0002); fetch(32'h0000_0200); fetch(32'h8000_0004);
        fetch(32'h0000_0011); fetch(32'hFFFF_FFFC); fetch(32'h0000_01FC);
        idle();

        // stall holds through address changes; flush beats stall
        fetch(32'h4);
        for (int j = 0; j < 3; j++) cyc(1, 1, 0, 32'($urandom_range(0, 127)) << 2, 0, 0, 32'h0, 0);
        cyc(1, 1, 0, 32'h0000_0002, 0, 0, 32'h0, 0);
        cyc(1, 1, 1, 32'h8, 0, 0, 32'h0, 0);
        fetch(32'h0000_0003);
        cyc(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        idle();

        // fetch requests during LOAD; write on the load_end cycle
        cyc(1, 0, 0, 32'h4, 1, 0, 32'h0, 0);
        for (int j = 0; j < 3; j++) cyc(1, j[0], j == 1, 32'(j * 4), 0, 1, $urandom, 0);
        cyc(1, 0, 0, 32'h0, 0, 1, 32'hCAFE_F00D, 1);
        fetch(32'hC); fetch(32'h8);
        // start+we together: write ignored; we in RUN ignored
        cyc(0, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
        cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h1234_5678, 0);
        fetch(32'h0);
        idle();

        // asynchronous reset in the middle of a load session
        cyc(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h1111_2222, 0);
        cyc(0, 0, 0, 32'h0, 0, 1, 32'h3333_4444, 0);
        fetch_en = 0; load_we = 0;
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        #1 reset = 1'b0;
        fetch(32'h0); fetch(32'h4);
        idle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 127)) << 2;
            if (r == 7) a = a | 32'h8000_0000;
            else if (r == 8) a = $urandom;
            else if (r == 9) a = a + 32'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, a,
                $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined MIPS core. Replaces the fixed combinational ROM in the IF stage.
- Adds a runtime program-load port, fed by the UART bootloader, with an auto-incrementing write pointer.
- Adds registered fetch with stall/flush support, plus fault detection for misaligned and out-of-range fetches.
- Output register doubles as the IF/ID instruction register.

Parameters:
- DATA_W, 32, instruction word width
- DEPTH_LOG2, 7, log2 of word count (default 128 words)
- NOP_WORD, 32'h0000_0000, word driven on fault, flush, reset and load
- IGNORE_MSB, 1, when 1 addr[31] (supervisor bit) is excluded from the range check

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  fetch request this cycle
- stall  in  1  hold current output (IF/ID stall)
- flush  in  1  squash output (branch/jump/exception)
- addr  in  32  byte address of fetch (PC)
- instruction  out  DATA_W  registered instruction
- inst_valid  out  1  instruction holds a real fetched word
- addr_fault  out  1  registered: current output came from a bad address
- load_start  in  1  enter LOAD mode, clear write pointer
- load_we  in  1  write load_data at pointer, then increment pointer
- load_data  in  DATA_W  program word
- load_end  in  1  leave LOAD mode
- loading  out  1  high while in LOAD state
- load_count  out  DEPTH_LOG2+1  words accepted this session
- load_overflow  out  1  sticky: a write was dropped because memory was full

Behaviour:
- Storage: DEPTH = 2^DEPTH_LOG2 words. The array is not cleared by reset; contents survive reset and are changed only by load writes.
- States: RUN and LOAD.
- Reset (async): state=RUN; instruction=NOP_WORD; inst_valid=0; addr_fault=0; loading=0; load_count=0; load_overflow=0.
- RUN -> LOAD on load_start. LOAD -> RUN on load_end. load_start while in LOAD restarts the session: pointer 0, count 0, overflow cleared.
- Fetch (RUN), latency 1 cycle. Per-edge priority is flush > stall > fetch_en:
  - flush: instruction=NOP_WORD, inst_valid=0, addr_fault=0 (overrides stall).
  - stall: all three fetch outputs hold.
  - fetch_en: good address gives instruction=mem[addr[DEPTH_LOG2+1:2]], inst_valid=1, addr_fault=0. Bad address gives NOP_WORD, inst_valid=0, addr_fault=1.
  - else: inst_valid=0, instruction and addr_fault hold.
- Bad address means either of:
  - addr[1:0] != 0.
  - Any of addr[31-IGNORE_MSB : DEPTH_LOG2+2] is nonzero.
- No aliasing of out-of-range addresses.
- Load (LOAD state):
  - load_we with count < DEPTH writes mem[count] = load_data; count increments at the edge.
  - load_we with count == DEPTH drops the word and sets load_overflow; count saturates at DEPTH, no wrap.
- Load side conditions:
  - Fetch outputs are forced to NOP_WORD, inst_valid=0, addr_fault=0 every cycle in LOAD, regardless of fetch_en, stall and flush.
  - load_start with load_we in the same cycle: start wins, the write is ignored.
  - load_end with load_we in the same cycle: the write is performed, then RUN.
  - First fetch after load_end returns the new contents (write-before-read across the state change).
  - load_we, load_end and load_data are ignored in RUN.
  - load_count and load_overflow hold after load_end until the next load_start or reset.
- Reset mid-load: state=RUN. Words already written are retained; count and overflow are cleared.
- loading is registered and equals (state==LOAD).

Test Plan:
1. Load then fetch: load_start, then load_we 3 words 0x20080014, 0x01000008, 0x3c104000, then load_end. Fetch addr 0x0, 0x4, 0x8 on consecutive cycles -> those words one cycle later, inst_valid=1, load_count=3.
2. Overflow: DEPTH_LOG2=2, load_start then 5 load_we -> load_count=4, load_overflow=1. mem[0..3] hold the first 4 words; the 5th is dropped.
3. Faults: fetch 0x00000002 -> NOP, addr_fault=1, inst_valid=0. Fetch 0x00000200 (DEPTH_LOG2=7) -> addr_fault=1. Fetch 0x80000004 with IGNORE_MSB=1 -> mem[1], no fault. Same fetch with IGNORE_MSB=0 -> fault.
4. Stall/flush: fetch 0x4, then assert stall for 3 cycles while addr changes -> output holds mem[1]. Stall+flush in the same cycle -> NOP, inst_valid=0 next cycle.
5. Mode interaction: fetch_en held high during LOAD -> NOP, inst_valid=0 throughout. load_end+load_we on the same cycle -> last word written; the following fetch of that address returns it.
6. Async reset mid-load: after 2 writes, pulse reset between clock edges -> outputs reset immediately, loading=0. A subsequent fetch of 0x0 and 0x4 returns the 2 loaded words.
